// File: rtl/frame_buffer_writer_if.sv
// Pixel stream and double-buffer write port bundle for frame_buffer_writer.
// The writer takes the slave view; the pixel source / buffer model takes the master view.
interface frame_buffer_writer_if #(
  parameter int AW = 10
);
  logic          pix_valid;
  logic [23:0]   pix_data;
  logic          pix_sof;
  logic          pix_ready;
  logic          buf0_empty;
  logic          buf1_empty;
  logic          we0;
  logic          we1;
  logic [AW-1:0] waddr;
  logic [23:0]   wdata;
  logic          buf0_full;
  logic          buf1_full;

  modport slave (
    input  pix_valid, pix_data, pix_sof, buf0_empty, buf1_empty,
    output pix_ready, we0, we1, waddr, wdata, buf0_full, buf1_full
  );

  modport master (
    output pix_valid, pix_data, pix_sof, buf0_empty, buf1_empty,
    input  pix_ready, we0, we1, waddr, wdata, buf0_full, buf1_full
  );
endinterface

// File: rtl/frame_buffer_writer.sv
// Writes an incoming pixel stream into two ping-pong frame buffers, one full frame each,
// checking start-of-frame framing and handing finished buffers to the display side.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// WAIT_BUF | target buffer still owned by display; wait for its empty flag
// FILL     | accepting pixels into target buffer, addr_q = next pixel index
module frame_buffer_writer #(
  parameter int H_PIX   = 10,
  parameter int V_LINES = 10,
  parameter int AW      = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_buffer_writer_if.slave bus,
  output logic                 frame_err_o,
  output logic [7:0]           frame_cnt_o
);

  localparam int              NPIX      = H_PIX * V_LINES;
  localparam logic [AW-1:0]   LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic {WAIT_BUF = 1'b0, FILL = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          tgt_q, tgt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we0_q, we0_d;
  logic          we1_q, we1_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [23:0]   wdata_q, wdata_d;
  logic          full0_q, full0_d;
  logic          full1_q, full1_d;
  logic          err_q, err_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          tgt_empty;
  logic          accept;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign tgt_empty = tgt_q ? bus.buf1_empty : bus.buf0_empty;
  assign accept    = bus.pix_valid && (state_q == FILL);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    full0_d = full0_q;
    full1_d = full1_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = addr_q;
    we0_d   = 1'b0;
    we1_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      WAIT_BUF: begin
        if (tgt_empty) begin
          state_d = FILL;
          addr_d  = '0;
          if (tgt_q) full1_d = 1'b0;
          else       full0_d = 1'b0;
        end
      end
      FILL: begin
        if (accept) begin
          if (bus.pix_sof) begin
            // sof always (re)starts the frame, even on what would be the last pixel
            wr_en   = 1'b1;
            wr_addr = '0;
            addr_d  = AW'(1);
            err_d   = (addr_q != '0);
          end else if (addr_q == '0) begin
            err_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_addr = addr_q;
            addr_d  = addr_q + AW'(1);
            if (addr_q == LAST_ADDR) begin
              state_d = WAIT_BUF;
              tgt_d   = ~tgt_q;
              addr_d  = '0;
              cnt_d   = cnt_q + 8'd1;
              if (tgt_q) full1_d = 1'b1;
              else       full0_d = 1'b1;
            end
          end
        end
      end
    endcase

    if (wr_en) begin
      we0_d   = ~tgt_q;
      we1_d   = tgt_q;
      waddr_d = wr_addr;
      wdata_d = bus.pix_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_BUF;
      tgt_q   <= 1'b0;
      addr_q  <= '0;
      we0_q   <= 1'b0;
      we1_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      we0_q   <= we0_d;
      we1_q   <= we1_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      full0_q <= full0_d;
      full1_q <= full1_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pix_ready = (state_q == FILL);
  assign bus.we0       = we0_q;
  assign bus.we1       = we1_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.buf0_full = full0_q;
  assign bus.buf1_full = full1_q;
  assign frame_err_o   = err_q;
  assign frame_cnt_o   = cnt_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Self-checking bench for frame_buffer_writer: constant vector table, directed frame
// sequences and randomized traffic against a frame-level reference model.
module tb_frame_buffer_writer;
  localparam int H_PIX   = 10;
  localparam int V_LINES = 10;
  localparam int AW      = 10;
  localparam int NPIX    = H_PIX * V_LINES;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_err;
  logic [7:0] frame_cnt;

  frame_buffer_writer_if #(.AW(AW)) bus ();

  frame_buffer_writer #(.H_PIX(H_PIX), .V_LINES(V_LINES), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .frame_err_o (frame_err),
    .frame_cnt_o (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame-level view (is a frame being filled, how many pixels of it so far)
  bit            m_filling;
  bit            m_tgt;
  int            m_pos;
  bit            m_full [2];
  int            m_frames;
  logic [AW-1:0] m_waddr;
  logic [23:0]   m_wdata;
  bit            e_we0, e_we1, e_err;

  typedef struct {
    bit          v;
    bit          s;
    logic [23:0] d;
    bit          e0;
    bit          e1;
    bit          rdy;
    bit          we0;
    bit          we1;
    logic [AW-1:0] waddr;
    logic [23:0] wdata;
    bit          err;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_filling = 1'b0;
    m_tgt     = 1'b0;
    m_pos     = 0;
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    m_frames  = 0;
    m_waddr   = '0;
    m_wdata   = '0;
  endtask

  task automatic expect_write(input int a, input logic [23:0] d);
    e_we0   = !m_tgt;
    e_we1   = m_tgt;
    m_waddr = AW'(a);
    m_wdata = d;
  endtask

  // One clock cycle: drive inputs, check ready, advance model, check registered outputs.
  task automatic step(input bit v, input bit s, input logic [23:0] d, input bit e0, input bit e1,
                      output bit rdy_seen);
    bus.pix_valid  = v;
    bus.pix_sof    = s;
    bus.pix_data   = d;
    bus.buf0_empty = e0;
    bus.buf1_empty = e1;
    #1;
    rdy_seen = bus.pix_ready;
    chk("pix_ready", {31'd0, bus.pix_ready}, {31'd0, m_filling});
    e_we0 = 1'b0;
    e_we1 = 1'b0;
    e_err = 1'b0;
    if (!m_filling) begin
      if (m_tgt ? e1 : e0) begin
        m_filling     = 1'b1;
        m_pos         = 0;
        m_full[m_tgt] = 1'b0;
      end
    end else if (v) begin
      if (s) begin
        e_err = (m_pos != 0);
        expect_write(0, d);
        m_pos = 1;
      end else if (m_pos == 0) begin
        e_err = 1'b1;
      end else begin
        expect_write(m_pos, d);
        m_pos++;
        if (m_pos == NPIX) begin
          m_full[m_tgt] = 1'b1;
          m_frames++;
          m_tgt     = !m_tgt;
          m_filling = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("we0", {31'd0, bus.we0}, {31'd0, e_we0});
    chk("we1", {31'd0, bus.we1}, {31'd0, e_we1});
    chk("waddr", 32'(bus.waddr), 32'(m_waddr));
    chk("wdata", 32'(bus.wdata), 32'(m_wdata));
    chk("buf0_full", {31'd0, bus.buf0_full}, {31'd0, m_full[0]});
    chk("buf1_full", {31'd0, bus.buf1_full}, {31'd0, m_full[1]});
    chk("frame_err", {31'd0, frame_err}, {31'd0, e_err});
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames % 256));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.pix_ready}, 32'd0);
    chk({tag, "_we0"}, {31'd0, bus.we0}, 32'd0);
    chk({tag, "_we1"}, {31'd0, bus.we1}, 32'd0);
    chk({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.wdata), 32'd0);
    chk({tag, "_full0"}, {31'd0, bus.buf0_full}, 32'd0);
    chk({tag, "_full1"}, {31'd0, bus.buf1_full}, 32'd0);
    chk({tag, "_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  // Asynchronous reset asserted between clock edges, released just after an edge.
  task automatic reset_mid();
    reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bit          r;
    int          n_we;
    bit          re0, re1, v, s;
    logic [23:0] d;

    tbl[0] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 24'h000000, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 24'hDEAD01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 24'h000000, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 24'hAAAAAA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 24'h000000, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 24'h111111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 24'h111111, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 24'h222222, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd1, 24'h222222, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 24'h999999, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd1, 24'h222222, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 24'h333333, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 24'h333333, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 24'h444444, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd1, 24'h444444, 1'b0};

    bus.pix_valid  = 1'b0;
    bus.pix_sof    = 1'b0;
    bus.pix_data   = '0;
    bus.buf0_empty = 1'b0;
    bus.buf1_empty = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].e0, tbl[i].e1, r);
      chk($sformatf("tbl%0d_rdy", i), {31'd0, r}, {31'd0, tbl[i].rdy});
      chk($sformatf("tbl%0d_we0", i), {31'd0, bus.we0}, {31'd0, tbl[i].we0});
      chk($sformatf("tbl%0d_we1", i), {31'd0, bus.we1}, {31'd0, tbl[i].we1});
      chk($sformatf("tbl%0d_waddr", i), 32'(bus.waddr), 32'(tbl[i].waddr));
      chk($sformatf("tbl%0d_wdata", i), 32'(bus.wdata), 32'(tbl[i].wdata));
      chk($sformatf("tbl%0d_err", i), {31'd0, frame_err}, {31'd0, tbl[i].err});
    end

    // Full frame into buffer 0, data = address
    reset_mid();
    step(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, r);
    n_we = 0;
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, i == 0, 24'(i), 1'b1, 1'b0, r);
      if (bus.we0 === 1'b1) n_we++;
    end
    chk("f0_we0_count", 32'(n_we), 32'(NPIX));
    chk("f0_full", {31'd0, bus.buf0_full}, 32'd1);
    chk("f0_cnt", 32'(frame_cnt), 32'd1);
    chk("f0_ready_after", {31'd0, bus.pix_ready}, 32'd0);

    // Buffer 1 held by display: writer must stall
    repeat (5) step(1'b1, 1'b0, 24'($urandom), 1'b1, 1'b0, r);
    chk("f1_stall_ready", {31'd0, bus.pix_ready}, 32'd0);
    step(1'b0, 1'b0, 24'h0, 1'b1, 1'b1, r);
    chk("f1_ready", {31'd0, bus.pix_ready}, 32'd1);
    chk("f1_full_clear", {31'd0, bus.buf1_full}, 32'd0);

    // Restart of frame at address 57 in buffer 1
    for (int i = 0; i < 57; i++) step(1'b1, i == 0, 24'($urandom), 1'b0, 1'b1, r);
    step(1'b1, 1'b1, 24'h5757AA, 1'b0, 1'b1, r);
    chk("restart_err", {31'd0, frame_err}, 32'd1);
    chk("restart_we1", {31'd0, bus.we1}, 32'd1);
    chk("restart_waddr", 32'(bus.waddr), 32'd0);
    for (int i = 1; i < NPIX; i++) step(1'b1, 1'b0, 24'($urandom), 1'b0, 1'b1, r);
    chk("restart_cnt", 32'(frame_cnt), 32'd2);
    chk("restart_full1", {31'd0, bus.buf1_full}, 32'd1);

    // Valid toggling every cycle, buffer 0
    step(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, r);
    for (int k = 0; k < 2 * NPIX; k++)
      step((k % 2) == 0, k == 0, 24'(k / 2), 1'b1, 1'b0, r);
    chk("toggle_cnt", 32'(frame_cnt), 32'd3);
    chk("toggle_full0", {31'd0, bus.buf0_full}, 32'd1);

    // Reset at address 40 of buffer 1
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b1, r);
    for (int i = 0; i < 40; i++) step(1'b1, i == 0, 24'($urandom), 1'b0, 1'b1, r);
    chk("pre_rst_waddr", 32'(bus.waddr), 32'd39);
    reset_mid();
    step(1'b1, 1'b1, 24'h0, 1'b1, 1'b1, r);
    chk("post_rst_no_we0", {31'd0, bus.we0}, 32'd0);
    chk("post_rst_no_we1", {31'd0, bus.we1}, 32'd0);
    step(1'b1, 1'b1, 24'hABCDEF, 1'b1, 1'b1, r);
    chk("post_rst_we0", {31'd0, bus.we0}, 32'd1);
    chk("post_rst_waddr", 32'(bus.waddr), 32'd0);

    // Randomized traffic against the model
    re0 = 1'b1;
    re1 = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) re0 = !re0;
      if ($urandom_range(0, 19) == 0) re1 = !re1;
      v = ($urandom_range(0, 3) != 0);
      if (m_filling && m_pos == 0) s = ($urandom_range(0, 7) != 0);
      else                         s = ($urandom_range(0, 149) == 0);
      d = 24'($urandom);
      step(v, s, d, re0, re1, r);
    end
    chk("rand_frames_seen", {31'd0, (m_frames > 5)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
